fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Sequences the fetch path that feeds the instruction buffer. It generates sequential fetch-group PCs toward the I-cache and tracks outstanding requests against a credit limit. Responses pass through to the instruction buffer's fetch-group port. On a backend redirect it flushes the instruction buffer, drops all stale in-flight responses, then restarts fetch at the redirect PC.

Parameters:
Cfg, config_pkg::EmptyCfg, global config; uses Cfg.PLEN, Cfg.ILEN, Cfg.INSTR_PER_FETCH.
RESET_PC, 32'h8000_0000, first fetch PC after reset; truncated or zero-extended to Cfg.PLEN.
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered I-cache requests; must be ≥1.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
redirect_valid_i  in  1  backend redirect request (single-cycle pulse, may repeat)
redirect_pc_i  in  Cfg.PLEN  redirect target, group-aligned by the producer
req_valid_o  out  1  fetch request valid to I-cache
req_ready_i  in  1  I-cache accepts request
req_pc_o  out  Cfg.PLEN  fetch group PC
rsp_valid_i  in  1  I-cache response valid
rsp_ready_o  out  1  controller accepts response
rsp_instrs_i  in  INSTR_PER_FETCH x ILEN  response instructions
rsp_pc_i  in  Cfg.PLEN  PC of response slot 0
fe_valid_o  out  1  fetch group valid to instruction buffer
fe_ready_i  in  1  instruction buffer accepts group
fe_instrs_o  out  INSTR_PER_FETCH x ILEN  forwarded instructions
fe_pc_o  out  Cfg.PLEN  forwarded group PC
ibuf_flush_o  out  1  flush pulse to instruction buffer
busy_o  out  1  high when state is not RUN

Behaviour:
- Registers: state {RUN, FLUSH, DRAIN}, pc_q, outst_q (width $clog2(MAX_OUTSTANDING+1)).
- Reset (rst_i high at posedge): state=RUN, pc_q=RESET_PC, outst_q=0. While rst_i is high, all outputs are forced low: req_valid_o, rsp_ready_o, fe_valid_o, ibuf_flush_o, busy_o.
- GROUP_BYTES = INSTR_PER_FETCH*ILEN/8. pc_q advances by GROUP_BYTES on each request handshake. Addition is mod 2^PLEN; wrap is silent.
- RUN:
  - req_valid_o = (outst_q < MAX_OUTSTANDING) && !redirect_valid_i; req_pc_o = pc_q.
  - Responses pass through combinationally: fe_valid_o = rsp_valid_i, rsp_ready_o = fe_ready_i, data and PC forwarded unchanged. Zero latency, no storage.
- outst_q update each cycle: +1 on request handshake, −1 on response handshake (rsp_valid_i && rsp_ready_o); both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- A response while outst_q==0 is a protocol error; an assertion fires.
- Redirect (redirect_valid_i in any state):
  - Next state = FLUSH; pc_q is loaded with redirect_pc_i.
  - No request is issued in the redirect cycle, because req_valid_o is gated.
  - In RUN, a response handshake in the redirect cycle is still forwarded; the FLUSH pulse removes it from the instruction buffer.
- FLUSH (exactly 1 cycle):
  - ibuf_flush_o=1, req_valid_o=0, fe_valid_o=0, rsp_ready_o=1; responses are dropped and decrement outst_q.
  - Next state = DRAIN, or RUN directly if outst_q reaches 0 this cycle.
- DRAIN:
  - ibuf_flush_o=0, req_valid_o=0, fe_valid_o=0, rsp_ready_o=1; every response is dropped and decrements outst_q.
  - Go to RUN in the cycle after outst_q becomes 0. The first new request is issued in RUN at pc_q = the latest redirect target.
- Redirect during FLUSH or DRAIN: pc_q is overwritten (latest wins) and state returns to FLUSH, so ibuf_flush_o pulses again. Outstanding accounting is preserved.
- busy_o = (state != RUN).
- Asserted invariant: ibuf_flush_o is only high in FLUSH.

Test Plan:
- Reset then free-running fetch: MAX_OUTSTANDING=4, I-cache always ready, no responses → four requests at PCs 0x8000_0000, 0x8000_0010, 0x8000_0020, 0x8000_0030; req_valid_o then low, outst_q=4.
- Credit recycle: with 4 outstanding, a response arrives with fe_ready_i=1 → forwarded same cycle (fe_pc_o=rsp_pc_i); the next cycle issues a request at 0x8000_0040. Simultaneous request and response handshake keeps outst_q constant.
- Backpressure: fe_ready_i=0 with rsp_valid_i=1 → rsp_ready_o=0, outst_q unchanged, no data lost; the response is accepted when fe_ready_i rises.
- Redirect with 3 outstanding: redirect_pc_i=0x8000_1000 → ibuf_flush_o high for 1 cycle, 3 responses dropped (fe_valid_o=0), busy_o high, then first request at 0x8000_1000.
- Redirect with 0 outstanding: FLUSH goes straight to RUN, so the new request is issued 2 cycles after the redirect. A second redirect (0x8000_2000) during DRAIN → another flush pulse, and fetch resumes at 0x8000_2000 only.
- Mid-operation reset: assert rst_i while in DRAIN with 2 outstanding → all outputs low during reset, then RUN, outst_q=0, next request at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - config package and fetch/redirect handshake interface
package config_pkg;
   typedef struct packed {
      int unsigned PLEN;
      int unsigned ILEN;
      int unsigned INSTR_PER_FETCH;
   } cfg_t;

   localparam cfg_t EmptyCfg = '{PLEN: 32, ILEN: 32, INSTR_PER_FETCH: 4};
endpackage

interface fetch_redirect_ctrl_if #(
   parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg
);
   localparam int PLEN = int'(Cfg.PLEN);
   localparam int ILEN = int'(Cfg.ILEN);
   localparam int IPF  = int'(Cfg.INSTR_PER_FETCH);

   logic                           redirect_valid_i;
   logic [PLEN-1:0]                redirect_pc_i;
   logic                           req_valid_o;
   logic                           req_ready_i;
   logic [PLEN-1:0]                req_pc_o;
   logic                           rsp_valid_i;
   logic                           rsp_ready_o;
   logic [IPF-1:0][ILEN-1:0]       rsp_instrs_i;
   logic [PLEN-1:0]                rsp_pc_i;
   logic                           fe_valid_o;
   logic                           fe_ready_i;
   logic [IPF-1:0][ILEN-1:0]       fe_instrs_o;
   logic [PLEN-1:0]                fe_pc_o;
   logic                           ibuf_flush_o;
   logic                           busy_o;

   // master: the fetch controller; slave: I-cache, backend and instruction buffer
   modport master (
      input  redirect_valid_i, redirect_pc_i, req_ready_i, rsp_valid_i,
             rsp_instrs_i, rsp_pc_i, fe_ready_i,
      output req_valid_o, req_pc_o, rsp_ready_o, fe_valid_o, fe_instrs_o,
             fe_pc_o, ibuf_flush_o, busy_o
   );

   modport slave (
      output redirect_valid_i, redirect_pc_i, req_ready_i, rsp_valid_i,
             rsp_instrs_i, rsp_pc_i, fe_ready_i,
      input  req_valid_o, req_pc_o, rsp_ready_o, fe_valid_o, fe_instrs_o,
             fe_pc_o, ibuf_flush_o, busy_o
   );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - sequential fetch PC generator with credit limit and redirect flush/drain
module fetch_redirect_ctrl #(
   parameter config_pkg::cfg_t Cfg             = config_pkg::EmptyCfg,
   parameter logic [31:0]      RESET_PC        = 32'h8000_0000,
   parameter int               MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   fetch_redirect_ctrl_if.master bus
);
   localparam int PLEN = int'(Cfg.PLEN);
   localparam int ILEN = int'(Cfg.ILEN);
   localparam int IPF  = int'(Cfg.INSTR_PER_FETCH);
   localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [PLEN-1:0] RST_PC      = PLEN'(RESET_PC);
   localparam logic [PLEN-1:0] GROUP_BYTES = PLEN'(IPF * ILEN / 8);
   localparam logic [CW-1:0]   MAX_CNT     = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [PLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outst_q, outst_d;

   logic req_valid, rsp_ready, fe_valid, flush;
   logic req_hs, rsp_hs;

   always_comb begin
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      fe_valid  = 1'b0;
      flush     = 1'b0;
      unique case (state_q)
         RUN: begin
            req_valid = (outst_q < MAX_CNT) && !bus.redirect_valid_i;
            fe_valid  = bus.rsp_valid_i;
            rsp_ready = bus.fe_ready_i;
         end
         FLUSH: begin
            flush     = 1'b1;
            rsp_ready = 1'b1;
         end
         DRAIN: begin
            rsp_ready = 1'b1;
         end
         default: ;
      endcase
      // Reset must look idle to both neighbours even mid-transaction
      if (rst_i) begin
         req_valid = 1'b0;
         rsp_ready = 1'b0;
         fe_valid  = 1'b0;
         flush     = 1'b0;
      end
   end

   assign req_hs = req_valid && bus.req_ready_i;
   assign rsp_hs = bus.rsp_valid_i && rsp_ready;

   always_comb begin
      outst_d = outst_q;
      if (req_hs && !rsp_hs) begin
         outst_d = outst_q + CW'(1);
      end else if (!req_hs && rsp_hs) begin
         outst_d = outst_q - CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (req_hs) begin
         pc_d = pc_q + GROUP_BYTES;
      end
      unique case (state_q)
         RUN:     state_d = RUN;
         FLUSH:   state_d = (outst_d == '0) ? RUN : DRAIN;
         DRAIN:   state_d = (outst_d == '0) ? RUN : DRAIN;
         default: state_d = RUN;
      endcase
      // Latest redirect wins, and the buffer must be flushed again for it
      if (bus.redirect_valid_i) begin
         state_d = FLUSH;
         pc_d    = bus.redirect_pc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         pc_q    <= RST_PC;
         outst_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
      end
   end

   assign bus.req_valid_o  = req_valid;
   assign bus.req_pc_o     = pc_q;
   assign bus.rsp_ready_o  = rsp_ready;
   assign bus.fe_valid_o   = fe_valid;
   assign bus.fe_instrs_o  = bus.rsp_instrs_i;
   assign bus.fe_pc_o      = bus.rsp_pc_i;
   assign bus.ibuf_flush_o = flush;
   assign bus.busy_o       = !rst_i && (state_q != RUN);

   a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.rsp_valid_i && outst_q == '0));
   a_flush_only_in_flush: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.ibuf_flush_o |-> state_q == FLUSH);
   a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      outst_q <= MAX_CNT);
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_redirect_ctrl_if #(.Cfg(config_pkg::EmptyCfg)) bus ();

   fetch_redirect_ctrl #(
      .Cfg(config_pkg::EmptyCfg),
      .RESET_PC(32'h8000_0000),
      .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are changed here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rsp(input logic v, input logic [31:0] pc);
      bus.rsp_valid_i  = v;
      bus.rsp_pc_i     = pc;
      bus.rsp_instrs_i = {pc ^ 32'h1111_1111, pc ^ 32'h2222_2222,
                          pc ^ 32'h3333_3333, pc ^ 32'h4444_4444};
   endtask

   logic [127:0] exp_instrs;

   initial begin
      rst                  = 1'b1;
      bus.redirect_valid_i = 1'b0;
      bus.redirect_pc_i    = '0;
      bus.req_ready_i      = 1'b1;
      bus.fe_ready_i       = 1'b1;
      rsp(1'b1, 32'h0);
      tick();
      tick();
      #1;
      check("rst_req_valid", bus.req_valid_o, 0);
      check("rst_rsp_ready", bus.rsp_ready_o, 0);
      check("rst_fe_valid", bus.fe_valid_o, 0);
      check("rst_flush", bus.ibuf_flush_o, 0);
      check("rst_busy", bus.busy_o, 0);
      rsp(1'b0, 32'h0);
      rst = 1'b0;

      // Free-running fetch until the credit limit
      for (int i = 0; i < 4; i++) begin
         #1;
         check("run_req_valid", bus.req_valid_o, 1);
         check("run_req_pc", bus.req_pc_o, 32'h8000_0000 + 32'(i) * 32'h10);
         tick();
      end
      #1;
      check("credit_stall", bus.req_valid_o, 0);
      check("outst_full", dut.outst_q, 4);
      check("run_busy", bus.busy_o, 0);

      // Credit recycle with same-cycle forwarding
      tick();
      rsp(1'b1, 32'h8000_0000);
      exp_instrs = {32'h9111_1111, 32'hA222_2222, 32'hB333_3333, 32'hC444_4444};
      #1;
      check("fwd_fe_valid", bus.fe_valid_o, 1);
      check("fwd_rsp_ready", bus.rsp_ready_o, 1);
      check("fwd_fe_pc", bus.fe_pc_o, 32'h8000_0000);
      check("fwd_instrs", bus.fe_instrs_o, exp_instrs);
      check("fwd_no_req", bus.req_valid_o, 0);
      tick();
      rsp(1'b1, 32'h8000_0010);
      #1;
      check("recycle_req_valid", bus.req_valid_o, 1);
      check("recycle_req_pc", bus.req_pc_o, 32'h8000_0040);
      tick();
      bus.req_ready_i = 1'b0;
      rsp(1'b0, 32'h0);
      #1;
      check("both_hs_outst", dut.outst_q, 3);
      check("next_req_pc", bus.req_pc_o, 32'h8000_0050);

      // Backpressure from the instruction buffer
      rsp(1'b1, 32'h8000_0020);
      bus.fe_ready_i = 1'b0;
      #1;
      check("bp_rsp_ready", bus.rsp_ready_o, 0);
      check("bp_fe_valid", bus.fe_valid_o, 1);
      tick();
      check("bp_outst_hold", dut.outst_q, 3);
      bus.fe_ready_i = 1'b1;
      #1;
      check("bp_release_ready", bus.rsp_ready_o, 1);
      check("bp_release_pc", bus.fe_pc_o, 32'h8000_0020);
      tick();
      rsp(1'b0, 32'h0);
      check("bp_outst_dec", dut.outst_q, 2);

      // Top up to 3 outstanding, then redirect
      bus.req_ready_i = 1'b1;
      tick();
      bus.req_ready_i = 1'b0;
      check("pre_redirect_outst", dut.outst_q, 3);
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h8000_1000;
      #1;
      check("redir_gates_req", bus.req_valid_o, 0);
      tick();
      bus.redirect_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rsp(1'b1, 32'h8000_0040 + 32'(i) * 32'h10);
         #1;
         check("drop_flush", bus.ibuf_flush_o, (i == 0) ? 1 : 0);
         check("drop_busy", bus.busy_o, 1);
         check("drop_fe_valid", bus.fe_valid_o, 0);
         check("drop_rsp_ready", bus.rsp_ready_o, 1);
         check("drop_req_valid", bus.req_valid_o, 0);
         tick();
      end
      rsp(1'b0, 32'h0);
      #1;
      check("resume_busy", bus.busy_o, 0);
      check("resume_req_valid", bus.req_valid_o, 1);
      check("resume_req_pc", bus.req_pc_o, 32'h8000_1000);

      // Redirect with nothing in flight: FLUSH goes straight back to RUN
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h8000_1800;
      tick();
      bus.redirect_valid_i = 1'b0;
      #1;
      check("zero_flush", bus.ibuf_flush_o, 1);
      tick();
      #1;
      check("zero_busy", bus.busy_o, 0);
      check("zero_req_valid", bus.req_valid_o, 1);
      check("zero_req_pc", bus.req_pc_o, 32'h8000_1800);

      // Two in flight, redirect, then a second redirect while draining
      bus.req_ready_i = 1'b1;
      tick();
      tick();
      bus.req_ready_i      = 1'b0;
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h8000_1F00;
      tick();
      bus.redirect_valid_i = 1'b0;
      tick();
      #1;
      check("drain_state_busy", bus.busy_o, 1);
      check("drain_no_flush", bus.ibuf_flush_o, 0);
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h8000_2000;
      tick();
      bus.redirect_valid_i = 1'b0;
      #1;
      check("reflush_pulse", bus.ibuf_flush_o, 1);
      check("reflush_outst", dut.outst_q, 2);
      for (int i = 0; i < 2; i++) begin
         rsp(1'b1, 32'h8000_1800 + 32'(i) * 32'h10);
         #1;
         check("reflush_fe_valid", bus.fe_valid_o, 0);
         tick();
      end
      rsp(1'b0, 32'h0);
      #1;
      check("reflush_req_pc", bus.req_pc_o, 32'h8000_2000);
      check("reflush_req_valid", bus.req_valid_o, 1);

      // Reset while draining with two in flight
      bus.req_ready_i = 1'b1;
      tick();
      tick();
      bus.req_ready_i      = 1'b0;
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h8000_5000;
      tick();
      bus.redirect_valid_i = 1'b0;
      tick();
      #1;
      check("pre_rst_busy", bus.busy_o, 1);
      check("pre_rst_outst", dut.outst_q, 2);
      rst             = 1'b1;
      bus.req_ready_i = 1'b1;
      #1;
      check("mid_rst_req_valid", bus.req_valid_o, 0);
      check("mid_rst_rsp_ready", bus.rsp_ready_o, 0);
      check("mid_rst_busy", bus.busy_o, 0);
      check("mid_rst_flush", bus.ibuf_flush_o, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_outst", dut.outst_q, 0);
      check("post_rst_req_valid", bus.req_valid_o, 1);
      check("post_rst_req_pc", bus.req_pc_o, 32'h8000_0000);
      check("post_rst_busy", bus.busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
